// File: rtl/vga_scanout_reader.sv
// 640x480@60 scanout of a 320x240 3-bit frame buffer with 2x pixel doubling.
// Optional VGA_SCANOUT_BORDER_EN forces the outermost frame-buffer ring to white.
module vga_scanout_reader #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int FB_WIDTH    = 320,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  output logic [16:0] mem_address,
  input  logic [2:0]  mem_q,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_start,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [8:0] FB_W   = 9'(FB_WIDTH);
`ifdef VGA_SCANOUT_BORDER_EN
  localparam logic [8:0] FX_LAST = 9'(FB_WIDTH - 1);
  localparam logic [8:0] FY_LAST = 9'(V_VISIBLE / 2 - 1);
`endif

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
`ifdef VGA_SCANOUT_BORDER_EN
    logic border;
`endif
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [16:0] addr_q, addr_d;
  logic [16:0] fx_ext, fy_ext;
  logic        first_q, fs_q, fs_d;
  logic [2:0]  rgb_q, rgb_d;
  ctrl_t       ctrl_cur;
  ctrl_t [MEM_LATENCY:0] pipe_q;

  // Address tracks the counters' next value so it changes together with h/v.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    fs_d   = 1'b0;
    fx_ext = '0;
    fy_ext = '0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      fx_ext = 17'(h_d[9:1]);
      fy_ext = 17'(v_d[9:1]);
      if (h_d[9:1] < FB_W && v_d < V_VIS)
        addr_d = (fy_ext << 8) + (fy_ext << 6) + fx_ext;
      fs_d = first_q || (h_d == '0 && v_d == '0);
    end
  end

  always_comb begin
    ctrl_cur         = CTRL_IDLE;
    ctrl_cur.hs      = !(h_q >= HS_ON && h_q < HS_OFF);
    ctrl_cur.vs      = !(v_q >= VS_ON && v_q < VS_OFF);
    ctrl_cur.blank_n = (h_q < H_VIS) && (v_q < V_VIS);
`ifdef VGA_SCANOUT_BORDER_EN
    ctrl_cur.border  = ctrl_cur.blank_n &&
                       (h_q[9:1] == '0 || h_q[9:1] == FX_LAST ||
                        v_q[9:1] == '0 || v_q[9:1] == FY_LAST);
`endif
  end

  // Colour is sampled in the same tick the control word reaches the output stage.
  always_comb begin
    rgb_d = 3'b000;
    if (pipe_q[MEM_LATENCY-1].blank_n) begin
      rgb_d = mem_q;
`ifdef VGA_SCANOUT_BORDER_EN
      if (pipe_q[MEM_LATENCY-1].border) rgb_d = 3'b111;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      first_q <= 1'b1;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) pipe_q[i] <= CTRL_IDLE;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      fs_q   <= fs_d;
      if (pix_en) begin
        first_q   <= 1'b0;
        rgb_q     <= rgb_d;
        pipe_q[0] <= ctrl_cur;
        for (int i = 1; i <= MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign mem_address = addr_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign frame_start = fs_q;
  assign vga_r       = {8{rgb_q[2]}};
  assign vga_g       = {8{rgb_q[1]}};
  assign vga_b       = {8{rgb_q[0]}};
  assign vga_hs      = pipe_q[MEM_LATENCY].hs;
  assign vga_vs      = pipe_q[MEM_LATENCY].vs;
  assign vga_blank_n = pipe_q[MEM_LATENCY].blank_n;
  assign vga_sync_n  = 1'b0;

endmodule

// File: doc/vga_scanout_reader.md
Name: vga_scanout_reader

Overview:
- Read side of the game's 320x240 3-bit frame buffer: generates 640x480@60 VGA timing, fetches each frame-buffer pixel through a synchronous ROM/RAM read port, and drives the DAC and sync pins with 2x pixel doubling.
- Sits between the frame-buffer memory, which the level datapaths write via x/y/colour plots, and the board VGA connector.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- FB_WIDTH, 320, frame-buffer width; must equal H_VISIBLE/2
- MEM_LATENCY, 1, clock-enable ticks from mem_address to valid mem_q (1..3)

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  reset, synchronous, active-low
- pix_en  in  1  pixel tick (25 MHz strobe); all timing advances only when it is high
- mem_address  out  17  frame-buffer read address
- mem_q  in  3  frame-buffer data {R,G,B}
- vga_r, vga_g, vga_b  out  8 each  DAC colour
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_blank_n  out  1  high in the visible region
- vga_sync_n  out  1  constant 0
- frame_start  out  1  one-clock pulse at the start of each frame
- h_count, v_count  out  10 each  current raster counters (pre-pipeline)

Behaviour:
- Counters
  - h_count wraps from H_TOTAL-1 (800-1) to 0.
  - On wrap, v_count increments and wraps from V_TOTAL-1 (525-1) to 0.
  - Counters update only on clocks with pix_en=1.
- Address generation (registered, per pix_en)
  - fx = h_count>>1, fy = v_count>>1.
  - mem_address = (fy<<8)+(fy<<6)+fx, computed in 17 bits; the maximum in-range value is 76799.
  - Outside the visible region mem_address holds its last value; it never exceeds 76799.
- Pipeline
  - hs, vs and blank are derived from h_count/v_count and delayed through a shift pipeline of MEM_LATENCY+1 pix_en stages, so they align with mem_q.
  - The pipeline advances only on pix_en.
- Sync
  - hs is low for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC.
  - vs is low for V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC.
- Colour output (registered)
  - When the delayed blank_n is 1, each mem_q bit expands to 8'hFF or 8'h00 (R=bit2, G=bit1, B=bit0).
  - When blanked, the output is 0.
- frame_start: high for exactly one clock, on the pix_en clock where the counters transition to h=0, v=0.
- Reset
  - h/v counters = 0, mem_address = 0.
  - vga_hs = vga_vs = 1, vga_blank_n = 0, RGB = 0, frame_start = 0.
  - All pipeline stages are loaded with the inactive values (hs=1, vs=1, blank_n=0).
- Reset mid-frame restarts the frame at h=0, v=0 on the next pix_en; no partial sync pulse may be extended.
- pix_en held low: all outputs hold, no address change, frame_start stays 0.
- mem_q is sampled only on pix_en clocks; changes between ticks are ignored.

Optional Feature:
- Macro: VGA_SCANOUT_BORDER_EN
- Defined: visible pixels with fx=0, fx=319, fy=0 or fy=239 output 3'b111 (all 8'hFF), overriding mem_q. The override flag travels the same pipeline as blank.
- Undefined: colour comes from mem_q only; no extra logic.

Test Plan:
- Reset release, pix_en every 2nd clock, mem_q=3'b100 constant -> after MEM_LATENCY+1 ticks vga_r=8'hFF, vga_g=vga_b=0, blank_n=1; blank_n falls after exactly 640 visible ticks per line.
- Free run one line -> vga_hs low for exactly 96 pix_en ticks starting at delayed h=656. One frame -> vga_vs low for 2 lines starting at delayed v=490. frame_start pulses once per 420000 ticks.
- Addressing at h=2,v=0 -> mem_address=1. At h=639,v=479 -> 76799. At h=0,v=2 -> 320. Address never exceeds 76799 over a full frame.
- pix_en held low 20 clocks mid-line -> all outputs and counters frozen. Resume -> continues from the same h without skipping.
- reset asserted at h=700,v=491 (during hsync and vsync) -> next clock hs=vs=1, blank_n=0, counters 0. First frame_start occurs on the first pix_en after release.
- VGA_SCANOUT_BORDER_EN defined, mem_q=3'b000 -> pixels h=0..1, h=638..639, v=0..1 and v=478..479 output all 8'hFF; interior pixels output 0.
